accum_ram: RTL

Parametrised accumulating register-file RAM: one write port with load or read-modify-write accumulate, one registered read port, and a hardware clear sweep that zeroes the whole array after reset or on request. Successor to the fixed 4-bit, 16-entry RAM. Sits between the arithmetic front-end (adders, function units) and downstream consumers that read per-address running totals.

---
 rtl/accum_ram.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/accum_ram.sv
// Accumulating register-file RAM: load/accumulate write pipeline, registered read, clear sweep.
// Define ACCUM_SAT_EN to make accumulates saturate instead of wrapping.
module accum_ram #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              WE,
  input  logic              ACC,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  Di,
  input  logic [ADDR_W-1:0] RA,
  output logic [WIDTH-1:0]  Do,
  output logic              Cout,
  output logic              BUSY
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {SWEEP, RUN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              flush;
  logic              sweep_we;
  logic              s1_capture;
  logic              commit;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Stage 1: captured write plus the two candidate sources of the old value.
  logic              s1_valid_reg;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic [WIDTH-1:0]  s1_data_reg;
  logic              s1_acc_reg;
  logic [WIDTH-1:0]  s1_ram_reg;
  logic              s1_hit_reg;
  logic [WIDTH-1:0]  s1_fwd_reg;

  // Stage 2: result waiting to be committed.
  logic              s2_valid_reg;
  logic [ADDR_W-1:0] s2_addr_reg;
  logic [WIDTH-1:0]  s2_result_reg;
  logic              s2_cout_reg;

  logic [WIDTH-1:0]  old_value;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  result;
  logic              carry;

  // Next-state logic; flush marks any cycle that (re)enters the sweep.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    flush      = RST;
    sweep_we   = 1'b0;
    if (!RST) begin
      case (state_reg)
        SWEEP: begin
          sweep_we = 1'b1;
          if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg + ADDR_W'(1);
          end
        end
        RUN: begin
          if (CLR) begin
            flush      = 1'b1;
            state_next = SWEEP;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= SWEEP;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign BUSY       = (state_reg == SWEEP);
  assign s1_capture = WE && (state_reg == RUN) && !flush;
  assign commit     = s2_valid_reg && !flush;

  // Old value priority: write now in S2, then write that committed as S1 was captured, then RAM.
  always_comb begin
    if (s2_valid_reg && (s2_addr_reg == s1_addr_reg)) begin
      old_value = s2_result_reg;
    end else if (s1_hit_reg) begin
      old_value = s1_fwd_reg;
    end else begin
      old_value = s1_ram_reg;
    end
  end

  always_comb begin
    sum    = {1'b0, old_value} + {1'b0, s1_data_reg};
    result = s1_data_reg;
    carry  = 1'b0;
    if (s1_acc_reg) begin
`ifdef ACCUM_SAT_EN
      if (sum[WIDTH]) begin
        result = '1;
        carry  = 1'b1;
      end else begin
        result = sum[WIDTH-1:0];
        carry  = 1'b0;
      end
`else
      result = sum[WIDTH-1:0];
      carry  = sum[WIDTH];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      Cout         <= 1'b0;
    end else begin
      s1_valid_reg <= s1_capture;
      s2_valid_reg <= s1_valid_reg && !flush;
      if (commit) begin
        Cout <= s2_cout_reg;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (s1_capture) begin
      s1_addr_reg <= A;
      s1_data_reg <= Di;
      s1_acc_reg  <= ACC;
      s1_hit_reg  <= commit && (s2_addr_reg == A);
      s1_fwd_reg  <= s2_result_reg;
    end
    if (s1_valid_reg) begin
      s2_addr_reg   <= s1_addr_reg;
      s2_result_reg <= result;
      s2_cout_reg   <= carry;
    end
  end

  // Array write port (sweep has priority; commits cannot occur while sweeping).
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[cnt_reg] <= '0;
    end else if (commit) begin
      mem[s2_addr_reg] <= s2_result_reg;
    end
    s1_ram_reg <= mem[A];
  end

  // Read-first registered read port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Do <= '0;
    end else begin
      Do <= mem[RA];
    end
  end

endmodule
